// File: rtl/amm_pkt_fifo_slave.sv
// Avalon-MM slave wrapping a word FIFO with packet accounting.
// Words are pushed/popped through the DATA register. PKT_CNT tracks how many
// complete packets of PACKET_SIZE words are buffered, and irq tells the CPU
// that at least one whole packet is waiting. Read latency is a fixed 1 cycle.
module amm_pkt_fifo_slave #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int PACKET_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          avs_address,
    input  logic                avs_write,
    input  logic                avs_read,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    output logic                irq
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = $clog2(PACKET_SIZE);
    localparam int NPKT = DEPTH / PACKET_SIZE;
    localparam int CW   = $clog2(NPKT + 1);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [PW-1:0] WCNT_ONE = PW'(1);
    localparam logic [PW-1:0] WLAST    = PW'(PACKET_SIZE - 1);
    localparam logic [CW-1:0] PKT_ONE  = CW'(1);
    localparam logic [CW-1:0] PKT_MAX  = CW'(NPKT);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_IRQEN  = 2'd2;
    localparam logic [1:0] ADDR_PKTCNT = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       fill_q, fill_d;
    logic [PW-1:0]     wcnt_q, wcnt_d;
    logic [PW-1:0]     rcnt_q, rcnt_d;
    logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic              irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              irq_q, irq_d;

    logic        empty, full;
    logic        wr_cmd, data_wr, data_rd;
    logic        push, pop, ovf_set, udf_set;
    logic        pkt_inc, pkt_dec;
    logic [31:0] status_word;

    // Command decode; a simultaneous read and write is treated as a read only.
    always_comb begin
        empty   = (fill_q == '0);
        full    = (fill_q == FILL_MAX);
        wr_cmd  = avs_write & ~avs_read;
        data_wr = wr_cmd && (avs_address == ADDR_DATA) && (&avs_byteenable);
        data_rd = avs_read && (avs_address == ADDR_DATA);
        push    = data_wr & ~full;
        ovf_set = data_wr & full;
        pop     = data_rd & ~empty;
        udf_set = data_rd & empty;
        pkt_inc = push && (wcnt_q == WLAST);
        pkt_dec = pop && (rcnt_q == WLAST);
    end

    // STATUS register image built from current (pre-update) state.
    always_comb begin
        status_word       = '0;
        status_word[7:0]  = 8'(fill_q);
        status_word[16]   = empty;
        status_word[17]   = full;
        status_word[18]   = (pkt_cnt_q != '0);
        status_word[19]   = ovf_q;
        status_word[20]   = udf_q;
    end

    // Read data mux; holds the last value when no read is presented.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = avs_read;
        if (avs_read) begin
            rdata_d = '0;
            case (avs_address)
                ADDR_DATA:   if (!empty) rdata_d = mem_q[rd_ptr_q];
                ADDR_STATUS: rdata_d = DATA_W'(status_word);
                ADDR_IRQEN:  rdata_d[0] = irq_en_q;
                ADDR_PKTCNT: rdata_d = DATA_W'(pkt_cnt_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    // Next-state for pointers, counters, flags and the interrupt.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        pkt_cnt_d = pkt_cnt_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            wcnt_d   = (wcnt_q == WLAST) ? '0 : wcnt_q + WCNT_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            rcnt_d   = (rcnt_q == WLAST) ? '0 : rcnt_q + WCNT_ONE;
        end
        if (push && !pop)
            fill_d = fill_q + FILL_ONE;
        else if (pop && !push)
            fill_d = fill_q - FILL_ONE;

        if (pkt_inc && !pkt_dec && (pkt_cnt_q != PKT_MAX))
            pkt_cnt_d = pkt_cnt_q + PKT_ONE;
        else if (pkt_dec && !pkt_inc && (pkt_cnt_q != '0))
            pkt_cnt_d = pkt_cnt_q - PKT_ONE;

        if (wr_cmd && (avs_address == ADDR_STATUS)) begin
            if (avs_writedata[19]) ovf_d = 1'b0;
            if (avs_writedata[20]) udf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (udf_set) udf_d = 1'b1;

        if (wr_cmd && (avs_address == ADDR_IRQEN))
            irq_en_d = avs_writedata[0];
    end

    // irq follows the registered enable and packet count one cycle later.
    always_comb begin
        irq_d = irq_en_q & (pkt_cnt_q != '0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            pkt_cnt_q <= '0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            irq_q     <= irq_d;
        end
    end

    // FIFO storage; not reset, stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= avs_writedata;
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_amm_pkt_fifo_slave.sv
// Bench for amm_pkt_fifo_slave: bus tasks drive the Avalon-MM port, every read
// pushes its expected value to a scoreboard, and a monitor pops and compares
// whenever readdatavalid appears.
module tb_amm_pkt_fifo_slave;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic        avs_read;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb_q[$];
    string       sb_tag[$];
    logic [31:0] model_q[$];
    logic        rd_at_edge = 1'b0;

    amm_pkt_fifo_slave #(.DATA_W(32), .DEPTH(16), .PACKET_SIZE(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .avs_address      (avs_address),
        .avs_write        (avs_write),
        .avs_read         (avs_read),
        .avs_writedata    (avs_writedata),
        .avs_byteenable   (avs_byteenable),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .irq              (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        @(posedge clk);
        #1;
        avs_write      = 1'b0;
        avs_byteenable = 4'hF;
    endtask

    task automatic push_word(input logic [31:0] d);
        if (model_q.size() < 16) model_q.push_back(d);
        bus_wr(2'd0, d, 4'hF);
    endtask

    task automatic reg_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sb_q.push_back(exp);
        sb_tag.push_back(tag);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        avs_read    = 1'b0;
    endtask

    task automatic pop_word(input string tag);
        logic [31:0] e;
        e = (model_q.size() > 0) ? model_q.pop_front() : 32'h0;
        reg_rd(tag, 2'd0, e);
    endtask

    // Track which edges sampled a live read so valid timing can be checked.
    always @(posedge clk) rd_at_edge <= avs_read && reset_n;

    // Scoreboard monitor: compare read data and the one-cycle valid timing.
    always @(negedge clk) begin
        logic [31:0] e;
        string       t;
        if (avs_readdatavalid || rd_at_edge)
            chk("rdvalid_timing", 32'(avs_readdatavalid), 32'(rd_at_edge));
        if (avs_readdatavalid) begin
            chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                t = sb_tag.pop_front();
                chk(t, avs_readdata, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n        = 1'b0;
        avs_address    = 2'd0;
        avs_write      = 1'b0;
        avs_read       = 1'b0;
        avs_writedata  = 32'h0;
        avs_byteenable = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdvalid", 32'(avs_readdatavalid), 32'd0);
        chk("rst_rdata", avs_readdata, 32'h0);
        reset_n = 1'b1;

        reg_rd("rst_status", 2'd1, 32'h0001_0000);
        reg_rd("rst_pktcnt", 2'd3, 32'h0);
        reg_rd("rst_irqen", 2'd2, 32'h0);

        // One packet with interrupt enabled.
        bus_wr(2'd2, 32'h1, 4'hF);
        reg_rd("irqen_rb", 2'd2, 32'h1);
        push_word(32'h0010_0000);
        push_word(32'h1);
        push_word(32'h2);
        push_word(32'h3);
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        chk("irq_pkt1", 32'(irq), 32'd1);
        reg_rd("pktcnt_1", 2'd3, 32'h1);
        reg_rd("status_pkt1", 2'd1, 32'h0004_0004);

        // Drain the packet.
        for (int i = 0; i < 4; i++) pop_word("pop_pkt1");
        reg_rd("pktcnt_0", 2'd3, 32'h0);
        chk("irq_drained", 32'(irq), 32'd0);
        reg_rd("status_empty", 2'd1, 32'h0001_0000);

        // Underflow and its write-1-to-clear.
        pop_word("underflow_data");
        reg_rd("status_udf", 2'd1, 32'h0011_0000);
        bus_wr(2'd1, 32'h0010_0000, 4'hF);
        reg_rd("status_udf_clr", 2'd1, 32'h0001_0000);

        // Partial byteenable must not push.
        bus_wr(2'd0, 32'hDEAD_BEEF, 4'b0111);
        reg_rd("status_partial_be", 2'd1, 32'h0001_0000);

        // Overfill: 17th word dropped, overflow sticky.
        for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i));
        reg_rd("status_full_ovf", 2'd1, 32'h000E_0010);
        reg_rd("pktcnt_4", 2'd3, 32'h4);
        bus_wr(2'd1, 32'h0008_0000, 4'hF);
        reg_rd("status_ovf_clr", 2'd1, 32'h0006_0010);
        for (int i = 0; i < 16; i++) pop_word("pop_full");
        reg_rd("pktcnt_after_full", 2'd3, 32'h0);

        // Read and write in the same cycle: only the read happens.
        push_word(32'h0000_CAFE);
        avs_address   = 2'd0;
        avs_writedata = 32'h0000_BEEF;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        sb_q.push_back(model_q.pop_front());
        sb_tag.push_back("rw_same_cycle");
        @(posedge clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        reg_rd("status_rw_ignored", 2'd1, 32'h0001_0000);

        // Reset mid-packet with a read in flight.
        push_word(32'h0000_00E0);
        push_word(32'h0000_00E1);
        avs_address = 2'd0;
        avs_read    = 1'b1;
        reset_n     = 1'b0;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        reset_n  = 1'b1;
        model_q.delete();
        chk("irq_after_reset", 32'(irq), 32'd0);
        reg_rd("irqen_after_reset", 2'd2, 32'h0);
        reg_rd("status_after_reset", 2'd1, 32'h0001_0000);
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        reg_rd("pktcnt_post_reset", 2'd3, 32'h1);
        for (int i = 0; i < 4; i++) pop_word("pop_post_reset");

        // Back-to-back packet boundary: count never drops to zero.
        bus_wr(2'd2, 32'h1, 4'hF);
        for (int i = 0; i < 4; i++) push_word(32'h10 + 32'(i));
        for (int i = 0; i < 3; i++) push_word(32'h20 + 32'(i));
        for (int i = 0; i < 3; i++) pop_word("pop_b2b_pkt1");
        chk("irq_b2b_a", 32'(irq), 32'd1);
        push_word(32'h23);
        chk("irq_b2b_b", 32'(irq), 32'd1);
        pop_word("pop_b2b_last");
        chk("irq_b2b_c", 32'(irq), 32'd1);
        @(posedge clk);
        #1;
        chk("irq_b2b_d", 32'(irq), 32'd1);
        reg_rd("pktcnt_b2b", 2'd3, 32'h1);
        reg_rd("status_b2b", 2'd1, 32'h0004_0004);
        for (int i = 0; i < 4; i++) pop_word("pop_b2b_pkt2");
        repeat (2) @(posedge clk);
        #1;
        chk("irq_final", 32'(irq), 32'd0);
        chk("sb_left", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
